// File: rtl/clock_10mhz_enable_generator.sv
`default_nettype none
// ============================================================================
// Module      : clock_10mhz_enable_generator
// Description : Fractional clock-enable generator. A phase accumulator adds
//               RATIO_NUM every RUN cycle and emits a one-cycle CE pulse each
//               time it crosses RATIO_DEN, giving an average CE rate of
//               RATIO_NUM/RATIO_DEN of the clock. With the defaults (5/8) a
//               16 MHz clock yields a 10 MHz enable.
//
// Ports       : CLK_16MHZ_Input    - single clock
//               RST_Input          - synchronous active-high reset
//               Enable_Input       - level; high runs, low forces IDLE
//               Sync_Input         - one-cycle strobe, realigns phase to frame start
//               CE_10MHZ_Output    - registered one-cycle clock-enable pulses
//               Frame_Wrap_Output  - one-cycle pulse on each frame boundary
//               Running_Output     - high while in RUN
//               Pulse_Count_Output - 16-bit wrapping count of CE pulses
//
// Options     : CLKEN_PULSE_COUNT_EN - when defined, Pulse_Count_Output counts
//               CE pulses (cleared only by reset). When undefined it is tied
//               to zero and no counter is built.
//
// Revision    : 1.0 - initial release
// ============================================================================
module clock_10mhz_enable_generator #(
    parameter int RATIO_NUM = 5,
    parameter int RATIO_DEN = 8,
    parameter int ACC_WIDTH = 8
) (
    input  logic        CLK_16MHZ_Input,
    input  logic        RST_Input,
    input  logic        Enable_Input,
    input  logic        Sync_Input,
    output logic        CE_10MHZ_Output,
    output logic        Frame_Wrap_Output,
    output logic        Running_Output,
    output logic [15:0] Pulse_Count_Output
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if ((RATIO_NUM == 0) || (RATIO_NUM > RATIO_DEN)) begin : g_bad_ratio
        $error("clock_10mhz_enable_generator: RATIO_NUM must be in 1..RATIO_DEN");
    end
    if (ACC_WIDTH < $clog2(2 * RATIO_DEN)) begin : g_bad_acc_width
        $error("clock_10mhz_enable_generator: ACC_WIDTH too small for RATIO_DEN");
    end

    localparam int FRAME_W = (RATIO_DEN > 1) ? $clog2(RATIO_DEN) : 1;

    localparam logic [ACC_WIDTH:0]   c_num_ext  = (ACC_WIDTH+1)'(RATIO_NUM);
    localparam logic [ACC_WIDTH:0]   c_den_ext  = (ACC_WIDTH+1)'(RATIO_DEN);
    localparam logic [ACC_WIDTH-1:0] c_num      = ACC_WIDTH'(RATIO_NUM);
    localparam logic [ACC_WIDTH-1:0] c_den      = ACC_WIDTH'(RATIO_DEN);
    localparam logic [FRAME_W-1:0]   c_frm_last = FRAME_W'(RATIO_DEN - 1);
    localparam logic [FRAME_W-1:0]   c_frm_one  = FRAME_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [FRAME_W-1:0]     frame_q;
    logic                   ce_q;
    logic                   wrap_q;
    logic                   running_q;

    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_sum_ge;
    logic [ACC_WIDTH-1:0]   w_acc_wrap;
    logic                   w_ce_d;

    // One extra bit on the sum so acc + RATIO_NUM never overflows.
    assign w_sum      = {1'b0, acc_q} + c_num_ext;
    assign w_sum_ge   = (w_sum >= c_den_ext);
    // The wrapped result is always < RATIO_DEN, so modulo-2^ACC_WIDTH
    // arithmetic gives the exact value without needing the carry bit.
    assign w_acc_wrap = acc_q + c_num - c_den;

    // CE value that will be registered on this edge (accumulating RUN edge only).
    assign w_ce_d = (state_q == ST_RUN) && Enable_Input && !Sync_Input
                    && !RST_Input && w_sum_ge;

    always_ff @(posedge CLK_16MHZ_Input) begin
        if (RST_Input || !Enable_Input) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            frame_q   <= '0;
            ce_q      <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Entry edge: phase starts clean, no pulse yet.
                    state_q   <= ST_RUN;
                    running_q <= 1'b1;
                    acc_q     <= '0;
                    frame_q   <= '0;
                    ce_q      <= 1'b0;
                    wrap_q    <= 1'b0;
                end
                ST_RUN: begin
                    running_q <= 1'b1;
                    if (Sync_Input) begin
                        // Realign: this edge does not accumulate.
                        acc_q   <= '0;
                        frame_q <= '0;
                        ce_q    <= 1'b0;
                        wrap_q  <= 1'b0;
                    end else begin
                        ce_q  <= w_ce_d;
                        acc_q <= w_sum_ge ? w_acc_wrap : w_sum[ACC_WIDTH-1:0];
                        if (frame_q == c_frm_last) begin
                            frame_q <= '0;
                            wrap_q  <= 1'b1;
                        end else begin
                            frame_q <= frame_q + c_frm_one;
                            wrap_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    acc_q     <= '0;
                    frame_q   <= '0;
                    ce_q      <= 1'b0;
                    wrap_q    <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign CE_10MHZ_Output   = ce_q;
    assign Frame_Wrap_Output = wrap_q;
    assign Running_Output    = running_q;

`ifdef CLKEN_PULSE_COUNT_EN
    logic [15:0] pulse_cnt_q;

    // Counts every registered CE pulse; only reset clears it.
    always_ff @(posedge CLK_16MHZ_Input) begin
        if (RST_Input) begin
            pulse_cnt_q <= '0;
        end else if (w_ce_d) begin
            pulse_cnt_q <= pulse_cnt_q + 16'd1;
        end
    end

    assign Pulse_Count_Output = pulse_cnt_q;
`else
    logic w_unused_ce_d;
    assign w_unused_ce_d      = w_ce_d;
    assign Pulse_Count_Output = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_10mhz_enable_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_10mhz_enable_generator
// Description : Self-checking bench for clock_10mhz_enable_generator. A vector
//               table of {inputs, expected outputs} is applied one clock edge
//               at a time; expectations go through a scoreboard queue and are
//               compared 1 ns after the edge. A second instance with 8/8 ratio
//               shares the stimulus. With CLKEN_PULSE_COUNT_EN defined the
//               pulse counter and its wrap are also exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_10mhz_enable_generator;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sync;
    logic        ce, wrap, run;
    logic [15:0] pc;
    logic        ce2, wrap2, run2;
    logic [15:0] pc2;

    clock_10mhz_enable_generator dut (
        .CLK_16MHZ_Input    (clk),
        .RST_Input          (rst),
        .Enable_Input       (en),
        .Sync_Input         (sync),
        .CE_10MHZ_Output    (ce),
        .Frame_Wrap_Output  (wrap),
        .Running_Output     (run),
        .Pulse_Count_Output (pc)
    );

    clock_10mhz_enable_generator #(
        .RATIO_NUM (8),
        .RATIO_DEN (8),
        .ACC_WIDTH (8)
    ) dut2 (
        .CLK_16MHZ_Input    (clk),
        .RST_Input          (rst),
        .Enable_Input       (en),
        .Sync_Input         (sync),
        .CE_10MHZ_Output    (ce2),
        .Frame_Wrap_Output  (wrap2),
        .Running_Output     (run2),
        .Pulse_Count_Output (pc2)
    );

    initial clk = 1'b0;
    always #31 clk = ~clk;

    typedef struct {
        logic rst, en, sync;
        logic ce, wrap, run, ce2;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ce, wrap, run, ce2;
        logic [15:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    bit   pat [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    int   checks = 0;
    int   passes = 0;
    logic [15:0] exp_pc = 16'd0;

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, req);
    endtask

    function automatic void add(bit r, bit e, bit s, bit c, bit w, bit u, bit c2);
        vec_t v;
        v.rst = r; v.en = e; v.sync = s; v.ce = c; v.wrap = w; v.run = u; v.ce2 = c2;
        vecs.push_back(v);
    endfunction

    // Monitor: compares DUT outputs against the scoreboard after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("ce",    x.idx, {15'd0, ce},    {15'd0, x.ce});
                check("wrap",  x.idx, {15'd0, wrap},  {15'd0, x.wrap});
                check("run",   x.idx, {15'd0, run},   {15'd0, x.run});
                check("pcount", x.idx, pc, x.pc);
                check("ce_8of8",   x.idx, {15'd0, ce2},   {15'd0, x.ce2});
                check("wrap_8of8", x.idx, {15'd0, wrap2}, {15'd0, x.wrap});
                check("run_8of8",  x.idx, {15'd0, run2},  {15'd0, x.run});
`ifndef CLKEN_PULSE_COUNT_EN
                check("pcount_8of8", x.idx, pc2, 16'd0);
`endif
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t x;
        int   waited;
        rst = 1'b1; en = 1'b0; sync = 1'b0;

        // ---- Reset state ----
        add(1,0,0, 0,0,0,0);
        add(1,0,0, 0,0,0,0);
        // ---- Enable held for 17 edges: entry, then two frames ----
        add(0,1,0, 0,0,1,0);
        for (int k = 2; k <= 17; k++)
            add(0,1,0, pat[(k-2)%8], (k == 9 || k == 17), 1, 1);
        // ---- Reset with Enable and Sync high on a RUN edge ----
        add(1,1,1, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(0,0,1, 0,0,0,0);               // Sync in IDLE ignored
        // ---- Sync on RUN edge 5 ----
        add(0,1,1, 0,0,1,0);               // entry edge; Sync ignored in IDLE
        for (int k = 0; k < 3; k++) add(0,1,0, pat[k], 0, 1, 1);
        add(0,1,1, 0,0,1,0);               // edge 5: sync
        for (int k = 0; k < 8; k++) add(0,1,0, pat[k], (k == 7), 1, 1);
        // ---- Enable drop on edge 4 (where CE would be 1), re-enable on 7 ----
        for (int k = 0; k < 3; k++) add(0,1,0, pat[k], 0, 1, 1);
        add(0,0,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        add(0,1,0, 0,0,1,0);
        for (int k = 0; k < 8; k++) add(0,1,0, pat[k], (k == 7), 1, 1);
        // ---- Enable drop exactly on the frame-wrap edge ----
        for (int k = 0; k < 7; k++) add(0,1,0, pat[k], 0, 1, 1);
        add(0,0,0, 0,0,0,0);
        // ---- Reset mid-frame where CE would be 1, then restart ----
        add(0,1,0, 0,0,1,0);
        for (int k = 0; k < 4; k++) add(0,1,0, pat[k], 0, 1, 1);
        add(1,1,0, 0,0,0,0);
        add(0,1,0, 0,0,1,0);
        add(0,1,0, pat[0], 0, 1, 1);
        add(0,1,0, pat[1], 0, 1, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst  = vecs[i].rst;
            en   = vecs[i].en;
            sync = vecs[i].sync;
`ifdef CLKEN_PULSE_COUNT_EN
            if (vecs[i].rst) exp_pc = 16'd0;
            else if (vecs[i].ce) exp_pc = exp_pc + 16'd1;
`endif
            x.idx = i; x.ce = vecs[i].ce; x.wrap = vecs[i].wrap;
            x.run = vecs[i].run; x.ce2 = vecs[i].ce2; x.pc = exp_pc;
            sb.push_back(x);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

`ifdef CLKEN_PULSE_COUNT_EN
        // ---- 80 RUN edges give 50 pulses ----
        @(negedge clk); rst = 1'b1; en = 1'b0; sync = 1'b0;
        @(negedge clk); rst = 1'b0; en = 1'b1;   // entry edge follows
        repeat (81) @(negedge clk);
        check("pcount_80", 0, pc, 16'd50);
        // ---- Wrap 65535 -> 0 ----
        force dut.pulse_cnt_q = 16'd65534;
        #1;
        release dut.pulse_cnt_q;
        waited = 0;
        begin
            int seen;
            seen = 0;
            while (seen < 2 && waited < 20) begin
                @(posedge clk); #1;
                if (ce) seen++;
                waited++;
            end
            checks++;
            if (seen == 2) passes++;
            else $display("FAIL pcount_wrap_wait: got %0d pulses expected 2", seen);
        end
        check("pcount_wrap", 0, pc, 16'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_10mhz_enable_generator.md
CLOCK_10MHZ_ENABLE_GENERATOR -- requirements
Module: clock_10mhz_enable_generator

Interface
REQ-001 SHALL have parameter RATIO_NUM, default 5: enable pulses per frame.
REQ-002 SHALL have parameter RATIO_DEN, default 8: clock cycles per frame.
REQ-003 SHALL have parameter ACC_WIDTH, default 8: phase accumulator width, at least clog2(2*RATIO_DEN).
REQ-004 SHALL have port CLK_16MHZ_Input, input, 1 bit: the single clock, 16 MHz board clock.
REQ-005 SHALL have port RST_Input, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port Enable_Input, input, 1 bit: level; high runs the generator, low forces IDLE.
REQ-007 SHALL have port Sync_Input, input, 1 bit: single-cycle strobe that realigns phase.
REQ-008 SHALL have port CE_10MHZ_Output, output, 1 bit: registered one-cycle clock-enable pulses, average rate RATIO_NUM/RATIO_DEN of the clock.
REQ-009 SHALL have port Frame_Wrap_Output, output, 1 bit: one-cycle pulse on each frame boundary.
REQ-010 SHALL have port Running_Output, output, 1 bit: high while in RUN.
REQ-011 SHALL have port Pulse_Count_Output, output, 16 bits: count of CE pulses (see Configuration).

Function
REQ-012 SHALL implement two states, IDLE and RUN. IDLE goes to RUN on a clock edge with Enable_Input=1. RUN goes to IDLE on any edge with Enable_Input=0.
REQ-013 In IDLE: accumulator=0, frame counter=0, CE_10MHZ_Output=0, Frame_Wrap_Output=0, Running_Output=0.
REQ-014 The IDLE->RUN edge SHALL leave accumulator and frame counter at 0 and drive CE=0.
REQ-015 On each RUN edge: s = acc + RATIO_NUM. If s >= RATIO_DEN, then acc <= s - RATIO_DEN and CE <= 1; otherwise acc <= s and CE <= 0.
REQ-016 s SHALL be computed at ACC_WIDTH+1 bits so it never overflows.
REQ-017 Defaults SHALL produce the CE pattern 0,1,0,1,1,0,1,1 repeating, starting at the first RUN edge: 5 pulses per 8 cycles, no gap longer than 1 cycle.
REQ-018 Frame counter SHALL count 0..RATIO_DEN-1 on each RUN edge and wrap to 0. Frame_Wrap_Output <= 1 on the wrapping edge, else 0.
REQ-019 Accumulator SHALL be 0 on every frame wrap; phase is deterministic per frame.
REQ-020 Sync_Input=1 on a RUN edge SHALL set acc=0, frame=0, CE=0, Frame_Wrap=0, and suppress that edge's accumulation. The next edge resumes the REQ-017 pattern from its start.
REQ-021 Sync_Input SHALL be ignored in IDLE.
REQ-022 Priority SHALL be, highest first: RST_Input, then Enable_Input=0, then Sync_Input, then accumulate.
REQ-023 Enable_Input dropping mid-frame SHALL zero CE and Frame_Wrap on that same edge. Re-enabling SHALL restart the pattern from its start.
REQ-024 RATIO_NUM == RATIO_DEN SHALL give CE=1 on every RUN edge after the first.
REQ-025 RATIO_NUM == 0 or RATIO_NUM > RATIO_DEN SHALL be rejected at elaboration.
REQ-026 Running_Output SHALL be registered and equal to (state == RUN).

Reset
REQ-027 RST_Input=1 at an edge SHALL force IDLE and zero all outputs, accumulator, frame counter, and pulse counter, regardless of other inputs.
REQ-028 Reset asserted mid-frame SHALL abort with no CE pulse on that edge.
REQ-029 After reset releases, Enable_Input must be sampled high before the generator runs.

Configuration
REQ-030 Macro CLKEN_PULSE_COUNT_EN defined: Pulse_Count_Output increments by 1 on each edge where CE_10MHZ_Output is registered 1. It wraps 65535->0. Reset clears it; Sync and IDLE do not.
REQ-031 Macro CLKEN_PULSE_COUNT_EN undefined: Pulse_Count_Output SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-032 Reset, then Enable=1 held for 17 edges -> Running=1 after edge 1; CE over edges 2..17 = 0,1,0,1,1,0,1,1 twice; Frame_Wrap=1 on edges 9 and 17 only.
REQ-033 Sync=1 on RUN edge 5 -> CE=0 and Frame_Wrap=0 on edge 5; edges 6..13 replay 0,1,0,1,1,0,1,1.
REQ-034 Enable=0 on RUN edge 4, then Enable=1 on edge 7 -> CE=0 from edge 4; edge 7 enters RUN; pattern restarts at edge 8.
REQ-035 RST=1 with Enable=1 and Sync=1 on a RUN edge -> all outputs 0; state IDLE.
REQ-036 With CLKEN_PULSE_COUNT_EN defined, run 80 RUN edges -> Pulse_Count_Output=50. Preload the counter to 65534 via force and run to 2 more pulses -> 0.
REQ-037 RATIO_NUM=8, RATIO_DEN=8 -> CE=1 continuously from the second RUN edge.
